// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Owns the PC, drives the IRAM address
//               and waits out the IRAM's synchronous read latency. It then
//               captures the returned byte in the instruction register and
//               pulses ins_valid for one cycle. PC requests from the control
//               unit are honoured only while idle, so the IRAM address stays
//               stable while a read is in flight. A request that arrives
//               while busy is discarded and flagged on pc_op_drop.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               fetch_req             - start a fetch (ignored while busy)
//               pc_wen/pc_inc/pc_rst  - PC load / increment / reset requests
//               pc_din [ADDR_W]       - PC load value
//               mem_q  [DATA_W]       - IRAM read data
//               mem_addr [ADDR_W]     - IRAM address (same as pc)
//               pc [ADDR_W]           - current PC
//               ins [DATA_W]          - last fetched instruction
//               ins_valid             - ins was updated on the previous edge
//               busy                  - fetch in flight
//               pc_op_drop            - PC request discarded on the previous edge
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MEM_LAT  = 1,
    parameter int RESET_PC = 0,
    parameter int AUTO_INC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic              pc_wen,
    input  logic              pc_inc,
    input  logic              pc_rst,
    input  logic [ADDR_W-1:0] pc_din,
    input  logic [DATA_W-1:0] mem_q,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ins,
    output logic              ins_valid,
    output logic              busy,
    output logic              pc_op_drop
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // MEM_LAT is limited to 1..3, so a 2-bit wait counter is always enough.
    localparam logic [1:0]        c_lat      = 2'(MEM_LAT);
    localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] c_one      = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ins_q, ins_d;
    logic              ins_valid_q, ins_valid_d;
    logic              drop_q, drop_d;
    logic              w_pc_req;

    assign w_pc_req = pc_rst | pc_wen | pc_inc;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_d        = pc_q;
        ins_d       = ins_q;
        ins_valid_d = 1'b0;
        drop_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // The PC update lands on the same edge that starts a fetch,
                // so a jump-and-fetch reads from the new address.
                if (pc_rst) begin
                    pc_d = c_reset_pc;
                end else if (pc_wen) begin
                    pc_d = pc_din;
                end else if (pc_inc) begin
                    pc_d = pc_q + c_one;
                end
                if (fetch_req) begin
                    state_d = WAIT;
                    cnt_d   = 2'd0;
                end
            end
            WAIT: begin
                // PC must not move under an in-flight read; report the loss.
                drop_d = w_pc_req;
                if (cnt_q == c_lat) begin
                    state_d     = IDLE;
                    ins_d       = mem_q;
                    ins_valid_d = 1'b1;
                    if (AUTO_INC != 0) begin
                        pc_d = pc_q + c_one;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            pc_q        <= c_reset_pc;
            ins_q       <= '0;
            ins_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_q        <= pc_d;
            ins_q       <= ins_d;
            ins_valid_q <= ins_valid_d;
            drop_q      <= drop_d;
        end
    end

    assign mem_addr   = pc_q;
    assign pc         = pc_q;
    assign ins        = ins_q;
    assign ins_valid  = ins_valid_q;
    assign busy       = (state_q == WAIT);
    assign pc_op_drop = drop_q;

endmodule
`default_nettype wire
